mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Owns the single synchronous-read RAM port shared by instruction fetch and the memory stage.
- Sequences memory-stage ops: single-word LOAD/STORE, plus the two-word PUSH2/POP2 used by call, int and ret to save and restore the 32-bit PC as two 16-bit words.
- The memory stage always has priority. Fetch is granted only when the port is idle.
- Drives mem_stall to freeze the pipeline during multi-cycle ops and mem_done when an op completes.

Parameters:
- DATA_W, 16, RAM word width.
- ADDR_W, 12, RAM word-address width. All address arithmetic is modulo 2^ADDR_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_addr  in  ADDR_W  fetch address. A fetch is requested every cycle.
- if_grant  out  1  the RAM port carries if_addr this cycle.
- if_valid  out  1  if_rdata is valid (cycle after if_grant).
- if_rdata  out  DATA_W  fetched word.
- mem_op  in  3  000 NONE, 001 LOAD, 010 STORE, 011 PUSH2, 100 POP2. Codes 101-111 are treated as NONE. Held stable until mem_done.
- mem_addr  in  ADDR_W  LOAD/STORE address; stack address A for PUSH2/POP2.
- mem_wdata  in  2*DATA_W  STORE uses the low word; PUSH2 uses both words.
- mem_stall  out  1  pipeline freeze; op in progress and not completing this cycle.
- mem_done  out  1  one-cycle completion pulse.
- mem_rdata  out  2*DATA_W  LOAD result is {0, word}; POP2 result is {high, low}. Valid with mem_done, 0 otherwise.
- ram_addr  out  ADDR_W  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after the address is driven.

Behaviour:
- FSM states: IDLE, LD_WAIT, PUSH_LO, POP_HI, POP_WAIT. Reset state is IDLE.
- Reset values: low_reg 0, if_valid 0. In IDLE with mem_op NONE, ram_we=0, mem_stall=0 and mem_done=0.
- IDLE with NONE: ram_addr=if_addr, if_grant=1. Next cycle: if_valid=1, if_rdata=ram_rdata.
- IDLE with STORE:
  - ram_we=1, ram_addr=mem_addr, ram_wdata=mem_wdata[DATA_W-1:0].
  - mem_done=1 and mem_stall=0 in the same cycle; if_grant=0.
  - Stay in IDLE.
- IDLE with LOAD:
  - Read mem_addr; mem_stall=1; go to LD_WAIT.
  - LD_WAIT: mem_done=1, mem_rdata={0, ram_rdata}, mem_stall=0.
  - The fetch is granted in LD_WAIT. Go to IDLE.
- IDLE with PUSH2:
  - Write mem_wdata[2*DATA_W-1:DATA_W] at A; mem_stall=1; go to PUSH_LO.
  - PUSH_LO: write mem_wdata[DATA_W-1:0] at A-1; mem_done=1; mem_stall=0; go to IDLE.
- IDLE with POP2:
  - Read A (low word); mem_stall=1; go to POP_HI.
  - POP_HI: read A+1; capture ram_rdata into low_reg; mem_stall=1; go to POP_WAIT.
  - POP_WAIT: mem_done=1, mem_rdata={ram_rdata, low_reg}, mem_stall=0. The fetch is granted. Go to IDLE.
- Layout invariant: a PUSH2 at A followed by a POP2 at A-1 returns the pushed 32-bit value.
- if_grant is 0 in every cycle where the port is used by the memory stage. if_valid is the registered if_grant.
- The FSM advances only on state, never on re-sampling mem_op mid-op. A changed mem_op during a multi-cycle op is ignored until IDLE.
- Wrap-around: A=0 for PUSH2 writes the low word at 2^ADDR_W-1. A=2^ADDR_W-1 for POP2 reads the high word at 0.
- Back-to-back ops:
  - A new op may be presented the cycle after mem_done and is accepted immediately from IDLE.
  - Consecutive STOREs starve fetch. This is intended; the pipeline is frozen upstream anyway.
- Reset mid-op:
  - State returns to IDLE immediately. low_reg and if_valid clear.
  - A completed first word of a PUSH2 stays in RAM; no second write occurs.

Decomposition:
- Shared package mem_arb_pkg holds:
  - mem_op encodings (OP_NONE, OP_LOAD, OP_STORE, OP_PUSH2, OP_POP2).
  - FSM state encodings.
  - DATA_W and ADDR_W defaults.
- No sub-module: the single FSM, the address mux/adder and low_reg fit comfortably in one module.

Test Plan:
- Fetch only: reset release, mem_op NONE, if_addr 0x010 then 0x011 -> if_grant=1 every cycle; if_valid=1 one cycle later with RAM[0x010], then RAM[0x011].
- STORE then LOAD:
  - STORE 0x1234 at 0x020 -> ram_we=1 and mem_done=1 in the same cycle, mem_stall=0, if_grant=0.
  - LOAD 0x020 -> mem_stall=1 for 1 cycle, then mem_done with mem_rdata=0x00001234 and if_grant=1.
- PUSH2/POP2 round trip:
  - PUSH2 A=0x0FF, wdata 0xDEADBEEF -> RAM[0x0FF]=0xDEAD, RAM[0x0FE]=0xBEEF; mem_stall high 1 cycle.
  - POP2 A=0x0FE -> mem_stall high 2 cycles, then mem_rdata=0xDEADBEEF with mem_done.
- Wrap: PUSH2 A=0x000, wdata 0x11112222 -> RAM[0x000]=0x1111, RAM[0xFFF]=0x2222. POP2 A=0xFFF returns 0x11112222.
- Reset mid-op: assert rst during PUSH_LO -> state IDLE, no write to A-1, mem_stall=0, if_valid=0. After release, fetch resumes the next cycle.
- Illegal op plus mid-op change: mem_op=111 -> fetch granted, no RAM write. Change mem_op from POP2 to STORE in POP_HI -> POP2 completes normally, no write occurs.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings and default widths for the RAM port arbiter between fetch
// and the memory stage.
package mem_arb_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 12;

    typedef enum logic [2:0] {
        OP_NONE  = 3'b000,
        OP_LOAD  = 3'b001,
        OP_STORE = 3'b010,
        OP_PUSH2 = 3'b011,
        OP_POP2  = 3'b100
    } mem_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_WAIT,
        ST_PUSH_LO,
        ST_POP_HI,
        ST_POP_WAIT
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, memory-stage and RAM-side signals around the shared RAM port.
// The arbiter takes the slave view; the surrounding pipeline/RAM takes master.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
);

    logic [ADDR_W-1:0]   if_addr;
    logic                if_grant;
    logic                if_valid;
    logic [DATA_W-1:0]   if_rdata;

    logic [2:0]          mem_op;
    logic [ADDR_W-1:0]   mem_addr;
    logic [2*DATA_W-1:0] mem_wdata;
    logic                mem_stall;
    logic                mem_done;
    logic [2*DATA_W-1:0] mem_rdata;

    logic [ADDR_W-1:0]   ram_addr;
    logic                ram_we;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   ram_rdata;

    modport slave (
        input  if_addr, mem_op, mem_addr, mem_wdata, ram_rdata,
        output if_grant, if_valid, if_rdata, mem_stall, mem_done, mem_rdata,
               ram_addr, ram_we, ram_wdata
    );

    modport master (
        output if_addr, mem_op, mem_addr, mem_wdata, ram_rdata,
        input  if_grant, if_valid, if_rdata, mem_stall, mem_done, mem_rdata,
               ram_addr, ram_we, ram_wdata
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Single synchronous-read RAM port shared by fetch and the memory stage; the
// memory stage always wins, fetch only gets the port when it would be idle.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    arb_state_e          state;
    arb_state_e          state_next;
    logic [DATA_W-1:0]   low_reg;
    logic                if_valid_q;

    logic                grant;
    logic                we;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic                stall;
    logic                done;
    logic [2*DATA_W-1:0] rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            low_reg    <= '0;
            if_valid_q <= 1'b0;
        end else begin
            state      <= state_next;
            if_valid_q <= grant;
            if (state == ST_POP_HI)
                low_reg <= bus.ram_rdata;
        end
    end

    // mem_op is only decoded in IDLE; later states run purely on state so a
    // changed op mid-sequence is ignored. Everything is held quiet in reset.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        we         = 1'b0;
        addr       = bus.if_addr;
        wdata      = bus.mem_wdata[DATA_W-1:0];
        stall      = 1'b0;
        done       = 1'b0;
        rdata      = '0;
        if (rst) begin
            unique case (state)
                ST_IDLE: begin
                    case (bus.mem_op)
                        OP_STORE: begin
                            we   = 1'b1;
                            addr = bus.mem_addr;
                            done = 1'b1;
                        end
                        OP_LOAD: begin
                            addr       = bus.mem_addr;
                            stall      = 1'b1;
                            state_next = ST_LD_WAIT;
                        end
                        OP_PUSH2: begin
                            we         = 1'b1;
                            addr       = bus.mem_addr;
                            wdata      = bus.mem_wdata[2*DATA_W-1:DATA_W];
                            stall      = 1'b1;
                            state_next = ST_PUSH_LO;
                        end
                        OP_POP2: begin
                            addr       = bus.mem_addr;
                            stall      = 1'b1;
                            state_next = ST_POP_HI;
                        end
                        default: grant = 1'b1;
                    endcase
                end
                ST_LD_WAIT: begin
                    grant      = 1'b1;
                    done       = 1'b1;
                    rdata      = {{DATA_W{1'b0}}, bus.ram_rdata};
                    state_next = ST_IDLE;
                end
                ST_PUSH_LO: begin
                    we         = 1'b1;
                    addr       = bus.mem_addr - ADDR_W'(1);
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
                ST_POP_HI: begin
                    addr       = bus.mem_addr + ADDR_W'(1);
                    stall      = 1'b1;
                    state_next = ST_POP_WAIT;
                end
                ST_POP_WAIT: begin
                    grant      = 1'b1;
                    done       = 1'b1;
                    rdata      = {bus.ram_rdata, low_reg};
                    state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign bus.if_grant  = grant;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_rdata  = bus.ram_rdata;
    assign bus.mem_stall = stall;
    assign bus.mem_done  = done;
    assign bus.mem_rdata = rdata;
    assign bus.ram_addr  = addr;
    assign bus.ram_we    = we;
    assign bus.ram_wdata = wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural RAM, word-level shadow memory model,
// directed scenarios plus randomized back-to-back ops.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 12;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] ram_q;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    int unsigned   wr_count = 0;

    always @(posedge clk) begin
        if (ld_en)
            ram[ld_addr] <= ld_data;
        else if (bus.ram_we) begin
            ram[bus.ram_addr] <= bus.ram_wdata;
            wr_count <= wr_count + 1;
        end
        ram_q <= ram[bus.ram_addr];
    end
    assign bus.ram_rdata = ram_q;

    int passed = 0;
    int total  = 0;

    // Word-level view of each op: latency, write count, fetch grant on the
    // completing cycle, returned data; updates the shadow memory.
    function automatic void model_op(input logic [2:0] op, input logic [AW-1:0] a,
                                     input logic [31:0] wd, output int es, output int ew,
                                     output logic eg, output logic [31:0] er);
        logic [AW-1:0] am1, ap1;
        am1 = a - 1'b1;
        ap1 = a + 1'b1;
        es = 0; ew = 0; eg = 1'b0; er = '0;
        case (op)
            OP_STORE: begin ew = 1; model[a] = wd[15:0]; end
            OP_LOAD:  begin es = 1; eg = 1'b1; er = {16'h0, model[a]}; end
            OP_PUSH2: begin es = 1; ew = 2; model[a] = wd[31:16]; model[am1] = wd[15:0]; end
            OP_POP2:  begin es = 2; eg = 1'b1; er = {model[ap1], model[a]}; end
            default:  ;
        endcase
    endfunction

    // Presents one op and watches it to mem_done (bounded), then drops mem_op.
    task automatic run_op(input logic [2:0] op, input logic [AW-1:0] a, input logic [31:0] wd,
                          output int stalls, output logic done, output logic [31:0] rd,
                          output logic grant_busy, output logic grant_done);
        bus.mem_op = op; bus.mem_addr = a; bus.mem_wdata = wd;
        stalls = 0; done = 1'b0; rd = '0; grant_busy = 1'b0; grant_done = 1'b0;
        for (int c = 0; c < 6 && !done; c++) begin
            @(negedge clk);
            if (bus.mem_done) begin
                done = 1'b1; rd = bus.mem_rdata; grant_done = bus.if_grant;
            end else if (bus.if_grant) grant_busy = 1'b1;
            if (bus.mem_stall) stalls++;
            @(posedge clk); #1;
        end
        bus.mem_op = OP_NONE;
    endtask

    task automatic test_reset();
        bus.mem_op = OP_NONE;
        @(negedge clk);
        total++; if (bus.if_valid !== 1'b0) $display("FAIL reset_if_valid: got %b want 0", bus.if_valid); else passed++;
        total++; if (bus.mem_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", bus.mem_stall); else passed++;
        total++; if (bus.mem_done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.mem_done); else passed++;
        total++; if (bus.ram_we !== 1'b0) $display("FAIL reset_we: got %b want 0", bus.ram_we); else passed++;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        total++; if (bus.if_grant !== 1'b1) $display("FAIL release_grant: got %b want 1", bus.if_grant); else passed++;
        total++; if (bus.ram_we !== 1'b0) $display("FAIL release_we: got %b want 0", bus.ram_we); else passed++;
        total++; if (bus.if_valid !== 1'b0) $display("FAIL release_if_valid: got %b want 0", bus.if_valid); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_fetch();
        logic [AW-1:0] fa [22];
        fa[0] = 12'h010; fa[1] = 12'h011;
        for (int i = 2; i < 22; i++) fa[i] = AW'($urandom);
        for (int i = 0; i < 22; i++) begin
            bus.if_addr = fa[i];
            @(negedge clk);
            total++; if (bus.if_grant !== 1'b1 || bus.ram_addr !== fa[i])
                $display("FAIL fetch_grant[%0d]: got grant=%b addr=%h want 1 %h", i, bus.if_grant, bus.ram_addr, fa[i]);
            else passed++;
            if (i > 0) begin
                total++; if (bus.if_valid !== 1'b1 || bus.if_rdata !== model[fa[i-1]])
                    $display("FAIL fetch_data[%0d]: got v=%b d=%h want 1 %h", i, bus.if_valid, bus.if_rdata, model[fa[i-1]]);
                else passed++;
            end
            @(posedge clk); #1;
        end
    endtask

    typedef struct packed {
        logic [2:0]  op;
        logic [11:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
    } vec_t;

    task automatic test_store_push_pop_wrap();
        vec_t v [6];
        logic [11:0] ra [5];
        logic [15:0] rv [5];
        int st, es, ew; logic dn, gb, gd, eg; logic [31:0] rd, er;
        int unsigned w0;
        v[0] = '{OP_STORE, 12'h020, 32'h0000_1234, 32'h0};
        v[1] = '{OP_LOAD,  12'h020, 32'h0,         32'h0000_1234};
        v[2] = '{OP_PUSH2, 12'h0FF, 32'hDEAD_BEEF, 32'h0};
        v[3] = '{OP_POP2,  12'h0FE, 32'h0,         32'hDEAD_BEEF};
        v[4] = '{OP_PUSH2, 12'h000, 32'h1111_2222, 32'h0};
        v[5] = '{OP_POP2,  12'hFFF, 32'h0,         32'h1111_2222};
        for (int i = 0; i < 6; i++) begin
            w0 = wr_count;
            model_op(v[i].op, v[i].a, v[i].wd, es, ew, eg, er);
            run_op(v[i].op, v[i].a, v[i].wd, st, dn, rd, gb, gd);
            total++; if (!dn || st != es) $display("FAIL dir_timing[%0d]: got done=%b stalls=%0d want 1 %0d", i, dn, st, es); else passed++;
            total++; if (int'(wr_count - w0) != ew) $display("FAIL dir_writes[%0d]: got %0d want %0d", i, wr_count - w0, ew); else passed++;
            total++; if (gb || gd !== eg) $display("FAIL dir_grant[%0d]: got busy=%b done=%b want 0 %b", i, gb, gd, eg); else passed++;
            if (v[i].op == OP_LOAD || v[i].op == OP_POP2) begin
                total++; if (rd !== v[i].rd) $display("FAIL dir_rdata[%0d]: got %h want %h", i, rd, v[i].rd); else passed++;
            end
        end
        ra = '{12'h020, 12'h0FF, 12'h0FE, 12'h000, 12'hFFF};
        rv = '{16'h1234, 16'hDEAD, 16'hBEEF, 16'h1111, 16'h2222};
        for (int i = 0; i < 5; i++) begin
            total++; if (ram[ra[i]] !== rv[i]) $display("FAIL dir_ram[%h]: got %h want %h", ra[i], ram[ra[i]], rv[i]); else passed++;
        end
    endtask

    task automatic test_reset_mid_op();
        logic [AW-1:0] a;
        logic [DW-1:0] old_lo;
        int unsigned w0;
        a = 12'h300; old_lo = model[12'h2FF]; w0 = wr_count;
        bus.mem_op = OP_PUSH2; bus.mem_addr = a; bus.mem_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        total++; if (bus.mem_stall !== 1'b1) $display("FAIL rmid_first_stall: got %b want 1", bus.mem_stall); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.mem_stall !== 1'b0 || bus.ram_we !== 1'b0 || bus.mem_done !== 1'b0)
            $display("FAIL rmid_quiet: got stall=%b we=%b done=%b want 0 0 0", bus.mem_stall, bus.ram_we, bus.mem_done);
        else passed++;
        total++; if (bus.if_valid !== 1'b0) $display("FAIL rmid_if_valid: got %b want 0", bus.if_valid); else passed++;
        @(posedge clk); #1;
        bus.mem_op = OP_NONE; rst = 1'b1;
        @(negedge clk);
        total++; if (bus.if_grant !== 1'b1) $display("FAIL rmid_resume_grant: got %b want 1", bus.if_grant); else passed++;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (bus.if_valid !== 1'b1 || bus.if_rdata !== model[bus.if_addr])
            $display("FAIL rmid_resume_fetch: got v=%b d=%h want 1 %h", bus.if_valid, bus.if_rdata, model[bus.if_addr]);
        else passed++;
        @(posedge clk); #1;
        model[a] = 16'hCAFE;
        total++; if (wr_count - w0 != 1) $display("FAIL rmid_writes: got %0d want 1", wr_count - w0); else passed++;
        total++; if (ram[a] !== 16'hCAFE || ram[12'h2FF] !== old_lo)
            $display("FAIL rmid_ram: got %h %h want cafe %h", ram[a], ram[12'h2FF], old_lo);
        else passed++;
    endtask

    task automatic test_illegal_and_change();
        int unsigned w0;
        logic [31:0] exp;
        w0 = wr_count;
        bus.if_addr = 12'h040; bus.mem_op = 3'b111;
        @(negedge clk);
        total++; if (bus.if_grant !== 1'b1 || bus.ram_we !== 1'b0 || bus.mem_stall !== 1'b0 || bus.mem_done !== 1'b0)
            $display("FAIL illegal_op: got g=%b we=%b st=%b dn=%b want 1 0 0 0", bus.if_grant, bus.ram_we, bus.mem_stall, bus.mem_done);
        else passed++;
        @(posedge clk); #1;
        exp = {model[12'h0FF], model[12'h0FE]};
        bus.mem_op = OP_POP2; bus.mem_addr = 12'h0FE; bus.mem_wdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        bus.mem_op = OP_STORE;
        @(negedge clk);
        total++; if (bus.mem_stall !== 1'b1 || bus.ram_we !== 1'b0 || bus.mem_done !== 1'b0)
            $display("FAIL change_pop_hi: got st=%b we=%b dn=%b want 1 0 0", bus.mem_stall, bus.ram_we, bus.mem_done);
        else passed++;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (bus.mem_done !== 1'b1 || bus.mem_rdata !== exp || bus.ram_we !== 1'b0 || bus.if_grant !== 1'b1)
            $display("FAIL change_pop_done: got dn=%b rd=%h we=%b g=%b want 1 %h 0 1", bus.mem_done, bus.mem_rdata, bus.ram_we, bus.if_grant, exp);
        else passed++;
        @(posedge clk); #1;
        bus.mem_op = OP_NONE;
        total++; if (wr_count != w0) $display("FAIL change_writes: got %0d want 0", wr_count - w0); else passed++;
    endtask

    // Random ops issued back to back around the address wrap point.
    task automatic test_back_to_back();
        logic [2:0] op; logic [AW-1:0] a; logic [31:0] wd;
        int st, es, ew, errs; logic dn, gb, gd, eg; logic [31:0] rd, er;
        int unsigned w0;
        for (int i = 0; i < 200; i++) begin
            op = 3'($urandom_range(1, 4));
            a  = AW'($urandom_range(0, 31)) - 12'd8;
            wd = $urandom;
            w0 = wr_count;
            model_op(op, a, wd, es, ew, eg, er);
            run_op(op, a, wd, st, dn, rd, gb, gd);
            errs = 0;
            if (!dn || st != es) errs++;
            if (int'(wr_count - w0) != ew) errs++;
            if (gb || gd !== eg) errs++;
            if ((op == OP_LOAD || op == OP_POP2) && rd !== er) errs++;
            total++;
            if (errs != 0)
                $display("FAIL rand_op[%0d] op=%0d a=%h: got done=%b st=%0d wr=%0d g=%b/%b rd=%h want 1 %0d %0d 0/%b %h",
                         i, op, a, dn, st, wr_count - w0, gb, gd, rd, es, ew, eg, er);
            else passed++;
        end
        for (int i = 0; i < 32; i++) begin
            a = AW'(i) - 12'd8;
            total++; if (ram[a] !== model[a]) $display("FAIL rand_ram[%h]: got %h want %h", a, ram[a], model[a]); else passed++;
        end
    endtask

    initial begin
        bus.if_addr = '0; bus.mem_op = OP_NONE; bus.mem_addr = '0; bus.mem_wdata = '0;
        ld_en = 1'b1; ld_addr = '0; ld_data = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            ld_addr = AW'(i); ld_data = DW'($urandom); model[i] = ld_data;
            @(posedge clk); #1;
        end
        ld_en = 1'b0;
        test_reset();
        test_fetch();
        test_store_push_pop_wrap();
        test_reset_mid_op();
        test_illegal_and_change();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
        $fatal(1);
    end

endmodule
